// File: rtl/dma_req_agent_if.sv
// dma_req_if: peripheral write, count load and DMA handshake signals of dma_req_agent
interface dma_req_if;
  logic       wr_en;
  logic [1:0] wr_ch;
  logic [7:0] wr_data;
  logic [3:0] full;
  logic       tc_load;
  logic [1:0] tc_ch;
  logic [7:0] tc_value;
  logic [3:0] DREQ;
  logic [3:0] DACK;
  logic [7:0] IOData;
  logic       io_valid;
  logic [3:0] TC;
  logic       ack_err;
  modport slave (
    input  wr_en, wr_ch, wr_data, tc_load, tc_ch, tc_value, DACK,
    output full, DREQ, IOData, io_valid, TC, ack_err
  );
  modport master (
    output wr_en, wr_ch, wr_data, tc_load, tc_ch, tc_value, DACK,
    input  full, DREQ, IOData, io_valid, TC, ack_err
  );
endinterface

// File: rtl/dma_req_agent.sv
// dma_req_agent: four-channel DMA request agent with per-channel byte FIFOs; DMA_DEMAND_MODE_EN selects demand mode
module dma_req_agent #(
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  dma_req_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
`ifdef DMA_DEMAND_MODE_EN
  typedef enum logic [2:0] {IDLE, ARMED, REQ, DONE} st_t;
  localparam st_t AFTER_POP = REQ;
`else
  typedef enum logic [2:0] {IDLE, ARMED, REQ, HOLDOFF, DONE} st_t;
  localparam st_t AFTER_POP = HOLDOFF;
`endif
  st_t state_q [4];
  st_t state_d [4];
  logic [7:0] mem [4][FIFO_DEPTH];
  logic [AW-1:0] rd_q [4];
  logic [AW-1:0] wr_q [4];
  logic [AW:0] occ_q [4];
  logic [AW:0] occ_d [4];
  logic [8:0] cnt_q [4];
  logic [8:0] cnt_d [4];
  logic [3:0] tc_q, tc_d, push, pop, full_v, dreq_v;
  logic [7:0] head;
  logic one_hot, err;
  assign bus.full = full_v;
  assign bus.DREQ = dreq_v;
  assign bus.TC = tc_q;
  // ack legality, FIFO push/pop and next channel state; a count load overrides everything else
  always_comb begin
    one_hot = bus.DACK != 4'd0 && (bus.DACK & (bus.DACK - 4'd1)) == 4'd0;
    tc_d = tc_q;
    head = '0;
    for (int n = 0; n < 4; n++) begin
      full_v[n] = occ_q[n] == DEPTH;
      dreq_v[n] = state_q[n] == REQ;
      pop[n] = one_hot && bus.DACK[n] && dreq_v[n];
      push[n] = bus.wr_en && bus.wr_ch == 2'(n) && (!full_v[n] || pop[n]);
      occ_d[n] = occ_q[n] + {{AW{1'b0}}, push[n]} - {{AW{1'b0}}, pop[n]};
      cnt_d[n] = cnt_q[n];
      state_d[n] = state_q[n];
      if (pop[n]) head = mem[n][rd_q[n]];
      if (state_q[n] == ARMED && occ_q[n] != '0) state_d[n] = REQ;
`ifndef DMA_DEMAND_MODE_EN
      if (state_q[n] == HOLDOFF) state_d[n] = occ_q[n] != '0 ? REQ : ARMED;
`endif
      if (pop[n]) begin
        cnt_d[n] = cnt_q[n] - 9'd1;
        state_d[n] = cnt_d[n] == 9'd0 ? DONE : occ_d[n] == '0 ? ARMED : AFTER_POP;
        tc_d[n] = tc_q[n] | (cnt_d[n] == 9'd0);
      end
      if (bus.tc_load && bus.tc_ch == 2'(n)) begin
        cnt_d[n] = {bus.tc_value == 8'd0, bus.tc_value};
        state_d[n] = ARMED;
        tc_d[n] = 1'b0;
      end
    end
    err = bus.DACK != 4'd0 && pop == 4'd0;
  end
  // channel state, pointers, counts and registered data-path outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < 4; n++) begin
        state_q[n] <= IDLE;
        occ_q[n] <= '0;
        rd_q[n] <= '0;
        wr_q[n] <= '0;
        cnt_q[n] <= '0;
      end
      tc_q <= '0;
      bus.IOData <= '0;
      bus.io_valid <= 1'b0;
      bus.ack_err <= 1'b0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        state_q[n] <= state_d[n];
        occ_q[n] <= occ_d[n];
        rd_q[n] <= rd_q[n] + AW'(pop[n]);
        wr_q[n] <= wr_q[n] + AW'(push[n]);
        cnt_q[n] <= cnt_d[n];
      end
      tc_q <= tc_d;
      bus.IOData <= head;
      bus.io_valid <= |pop;
      bus.ack_err <= err;
    end
  end
  // FIFO storage needs no reset; occupancy guards every read
  always_ff @(posedge clk) begin
    for (int n = 0; n < 4; n++) if (push[n]) mem[n][wr_q[n]] <= bus.wr_data;
  end
endmodule
